// File: rtl/vga_sync_rx.sv
// VGA timing receiver: rebuilds hx/vy from sampled hsync/vsync, checks the
// timing against the configured mode and tracks lock.
module vga_sync_rx #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] hx,
    output logic [9:0] vy,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic       lock_lost,
    output logic [7:0] err_cnt
);

    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0] HX_SAT      = 10'd1023;
    localparam logic [9:0] HX_PRE_SAT  = 10'd1022;
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] PV_X_LO     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] PV_X_HI     = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0] VS_FIRST    = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] good;
    logic [GW-1:0] good_next;
    logic [GW-1:0] good_inc;

    logic          hsync_d;
    logic          vsync_ls;
    logic          ls;
    logic          hf;
    logic          v_rise;
    logic [9:0]    vy_next;
    logic          checking;
    logic          err_h_c;
    logic          err_v_c;
    logic          err_any;

    logic          locked_next;
    logic          lock_lost_next;
    logic          err_inc;

    // Edge detection and timing checks on the current sample
    always_comb begin
        ls       = hsync & ~hsync_d;
        hf       = ~hsync & hsync_d;
        v_rise   = ls & vsync & ~vsync_ls;
        vy_next  = (vy == V_LAST) ? 10'd0 : vy + 10'd1;
        good_inc = good + GW'(1);
        checking = (state != SEARCH);
        err_h_c  = checking & ((ls & (hx != H_LAST)) |
                               (hf & (hx != H_SYNC_LAST)) |
                               (~ls & (hx == HX_PRE_SAT)));
        err_v_c  = checking & ls &
                   (vsync != ((vy_next >= VS_FIRST) && (vy_next <= VS_LAST)));
        err_any  = err_h_c | err_v_c;
    end

    // Counter reconstruction; sync history resets high so a level held
    // across reset release is not seen as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_d  <= 1'b1;
            vsync_ls <= 1'b1;
            hx       <= 10'd0;
            vy       <= 10'd0;
        end else begin
            hsync_d <= hsync;
            if (ls) begin
                hx       <= 10'd0;
                vsync_ls <= vsync;
                vy       <= v_rise ? VS_FIRST : vy_next;
            end else if (hx != HX_SAT) begin
                hx <= hx + 10'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        good_next  = good;
        case (state)
            SEARCH: begin
                if (v_rise) begin
                    state_next = ALIGN;
                    good_next  = '0;
                end
            end
            ALIGN: begin
                if (err_any) begin
                    state_next = SEARCH;
                end else if (v_rise) begin
                    good_next = good_inc;
                    if (good_inc == GOOD_LOCK) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_next = SEARCH;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = '0;
            end
        endcase
    end

    // FSM output decode
    always_comb begin
        locked_next    = 1'b0;
        lock_lost_next = 1'b0;
        err_inc        = 1'b0;
        if (state_next == LOCKED) begin
            locked_next = 1'b1;
        end
        if ((state == LOCKED) && err_any) begin
            lock_lost_next = 1'b1;
            err_inc        = 1'b1;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            h_err     <= 1'b0;
            v_err     <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            locked    <= locked_next;
            lock_lost <= lock_lost_next;
            h_err     <= err_h_c;
            v_err     <= err_v_c;
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign pixel_valid = locked && (vy < V_ACT) && (hx >= PV_X_LO) && (hx < PV_X_HI);
    assign frame_start = locked && (hx == 10'd0) && (vy == 10'd0);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced 20x12 video mode
// (sync 4, back 2, active 8; 6 active lines, vsync on lines 8..9).
module tb_vga_sync_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic [9:0] hx;
    logic [9:0] vy;
    logic       pixel_valid;
    logic       frame_start;
    logic       locked;
    logic       h_err;
    logic       v_err;
    logic       lock_lost;
    logic [7:0] err_cnt;

    vga_sync_rx #(
        .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_TOTAL(20),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_TOTAL(12),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .hx(hx), .vy(vy), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked), .h_err(h_err), .v_err(v_err), .lock_lost(lock_lost),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int gx, gy;
    int n_herr, n_verr, n_lost, n_pv, n_fs, n_xy_bad;
    int herr_gx, herr_gy, herr_hx, verr_gx, verr_gy;
    int lock_gx, lock_gy;
    logic locked_q;
    bit track;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_herr = 0; n_verr = 0; n_lost = 0; n_pv = 0; n_fs = 0; n_xy_bad = 0;
        herr_gx = -1; herr_gy = -1; herr_hx = -1; verr_gx = -1; verr_gy = -1;
    endtask

    // One pixel clock: drive a sample, then observe the registered result
    task automatic step(input logic hs, input logic vs);
        hsync = hs;
        vsync = vs;
        @(posedge clk);
        #1;
        if (h_err) begin
            n_herr++; herr_gx = gx; herr_gy = gy; herr_hx = int'(hx);
        end
        if (v_err) begin
            n_verr++; verr_gx = gx; verr_gy = gy;
        end
        if (lock_lost) n_lost++;
        if (pixel_valid) n_pv++;
        if (frame_start) n_fs++;
        if (locked && !locked_q) begin
            lock_gx = gx; lock_gy = gy;
        end
        locked_q = locked;
        if (track && ((int'(hx) != gx) || (int'(vy) != gy))) n_xy_bad++;
    endtask

    task automatic run_line(input int y, input int total, input int hsw,
                            input bit vs_en, input int x0);
        gy = y;
        for (int x = x0; x < total; x++) begin
            gx = x;
            step(x < hsw, vs_en && (y == 8 || y == 9));
        end
    endtask

    task automatic run_frame(input bit vs_en, input int bad_y,
                             input int bad_total, input int bad_hsw);
        for (int y = 0; y < 12; y++) begin
            if (y == bad_y) run_line(y, bad_total, bad_hsw, vs_en, 0);
            else            run_line(y, 20, 4, vs_en, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0;
        gx = 0; gy = 0; locked_q = 1'b0; track = 1'b0;
        lock_gx = -1; lock_gy = -1;
        clr();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("reset_hx", int'(hx), 0);
        check("reset_vy", int'(vy), 0);
        check("reset_status", int'({locked, h_err, v_err, lock_lost, pixel_valid, frame_start}), 0);
        check("reset_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;

        // Ideal timing: lock at the LS of the 3rd vsync rise
        run_frame(1'b1, -1, 20, 4);
        check("f1_unlocked", int'(locked), 0);
        track = 1'b1;
        run_frame(1'b1, -1, 20, 4);
        check("f2_unlocked", int'(locked), 0);
        run_frame(1'b1, -1, 20, 4);
        check("f3_locked", int'(locked), 1);
        check("lock_line", lock_gy, 8);
        check("lock_col", lock_gx, 0);
        clr();
        run_frame(1'b1, -1, 20, 4);
        track = 1'b0;
        check("pv_per_frame", n_pv, 48);
        check("fs_per_frame", n_fs, 1);
        check("hx_vy_track", n_xy_bad, 0);
        check("clean_errs", n_herr + n_verr + n_lost, 0);
        check("clean_err_cnt", int'(err_cnt), 0);

        // Short line (19 clocks) while locked
        clr();
        run_frame(1'b1, 3, 19, 4);
        check("short_herr_n", n_herr, 1);
        check("short_herr_line", herr_gy, 4);
        check("short_herr_col", herr_gx, 0);
        check("short_lost_n", n_lost, 1);
        check("short_unlocked", int'(locked), 0);
        check("short_err_cnt", int'(err_cnt), 1);
        run_frame(1'b1, -1, 20, 4);
        check("short_relock_wait", int'(locked), 0);
        run_frame(1'b1, -1, 20, 4);
        check("short_relocked", int'(locked), 1);

        // Narrow hsync (3 clocks) while locked, from a fresh reset
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(1'b1, -1, 20, 4);
        check("narrow_pre_locked", int'(locked), 1);
        clr();
        run_frame(1'b1, 4, 20, 3);
        check("narrow_herr_n", n_herr, 1);
        check("narrow_herr_line", herr_gy, 4);
        check("narrow_herr_col", herr_gx, 3);
        check("narrow_lost_n", n_lost, 1);
        check("narrow_err_cnt", int'(err_cnt), 1);

        // Missing vsync for one frame while locked
        run_frame(1'b1, -1, 20, 4);
        run_frame(1'b1, -1, 20, 4);
        check("novs_pre_locked", int'(locked), 1);
        clr();
        run_frame(1'b0, -1, 20, 4);
        check("novs_verr_n", n_verr, 1);
        check("novs_verr_line", verr_gy, 8);
        check("novs_verr_col", verr_gx, 0);
        check("novs_lost_n", n_lost, 1);
        check("novs_unlocked", int'(locked), 0);
        check("novs_err_cnt", int'(err_cnt), 2);

        // hsync stuck low in ALIGN: single saturation error
        run_frame(1'b1, -1, 20, 4);
        clr();
        gx = -1; gy = -1;
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b0);
        check("stuck_herr_n", n_herr, 1);
        check("stuck_herr_hx", herr_hx, 1023);
        check("stuck_hx_sat", int'(hx), 1023);
        check("stuck_lost_n", n_lost, 0);
        check("stuck_err_cnt", int'(err_cnt), 2);
        clr();
        run_frame(1'b1, -1, 20, 4);
        check("stuck_resume_herr", n_herr, 0);
        run_frame(1'b1, -1, 20, 4);
        run_frame(1'b1, -1, 20, 4);
        check("stuck_relocked", int'(locked), 1);

        // Reset mid-line with hsync high
        for (int y = 0; y < 3; y++) run_line(y, 20, 4, 1'b1, 0);
        gy = 3; gx = 0;
        step(1'b1, 1'b0);
        rst = 1'b1;
        gx = 1; step(1'b1, 1'b0);
        gx = 2; step(1'b1, 1'b0);
        check("midrst_hx", int'(hx), 0);
        check("midrst_vy", int'(vy), 0);
        check("midrst_status", int'({locked, h_err, v_err, lock_lost, pixel_valid, frame_start}), 0);
        check("midrst_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        gx = 3; step(1'b1, 1'b0);
        check("midrst_no_false_ls", int'(hx), 1);
        run_line(3, 20, 4, 1'b1, 4);
        for (int y = 4; y < 12; y++) run_line(y, 20, 4, 1'b1, 0);
        run_frame(1'b1, -1, 20, 4);
        check("midrst_relock_wait", int'(locked), 0);
        run_frame(1'b1, -1, 20, 4);
        check("midrst_relocked", int'(locked), 1);
        check("midrst_final_err_cnt", int'(err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the VGA timing produced by the video controller.
- Samples hsync/vsync on the pixel clock and rebuilds the hx/vy column/line counters, delayed by one cycle.
- Checks the timing against the 640x480 mode and acquires/loses lock.
- Used as a bench monitor and as the front end of a capture/compare path.

Parameters:
H_SYNC, 96, hsync pulse width in pixel clocks
H_BACK, 48, back porch
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, clocks per line
V_ACTIVE, 480, visible lines
V_FRONT, 10, front porch lines
V_SYNC, 2, vsync lines
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames needed for lock

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
hsync  in  1  horizontal sync, active-high
vsync  in  1  vertical sync, active-high
hx  out  10  rebuilt column number, 0..H_TOTAL-1
vy  out  10  rebuilt line number, 0..V_TOTAL-1
pixel_valid  out  1  locked, vy<V_ACTIVE, and H_SYNC+H_BACK <= hx < H_SYNC+H_BACK+H_ACTIVE
frame_start  out  1  1-cycle pulse when hx==0 and vy==0 while locked
locked  out  1  lock state
h_err  out  1  1-cycle horizontal timing error pulse
v_err  out  1  1-cycle vertical timing error pulse
lock_lost  out  1  1-cycle pulse on LOCKED -> SEARCH
err_cnt  out  8  errors counted while LOCKED; saturates at 255

Behaviour:
Interface and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- rst sets all outputs to 0 and the FSM to SEARCH.
- rst sets hsync_d=1 and vsync_d=1, so a sync line already high at reset release is not taken as an edge.
- Reset mid-frame discards all alignment; reacquisition starts from scratch.

Edges:
- hsync_d and vsync_d are the previous-cycle samples.
- Line start (LS): hsync=1 and hsync_d=0.
- Sync falling (HF): hsync=0 and hsync_d=1.

Horizontal counter:
- hx holds the index of the previous cycle's sample (1-cycle latency).
- LS loads hx <= 0. Otherwise hx increments, saturating at 1023.
- hx does not wrap at H_TOTAL; only LS restarts it.

Vertical counter, updated only at LS:
- vy_next = (vy == V_TOTAL-1) ? 0 : vy+1.
- If vsync=1 and the vsync sample at the previous LS was 0 (vsync rise): vy <= V_ACTIVE+V_FRONT (490). Otherwise vy <= vy_next.

Checks (active in ALIGN and LOCKED; each raises a 1-cycle pulse):
- h_err at LS if hx != H_TOTAL-1.
- h_err at HF if hx != H_SYNC-1.
- h_err once when hx first reaches 1023.
- v_err at LS if vsync != (490 <= vy_next <= 491). The vsync rise load is not checked separately.
- If h_err and v_err fire in the same cycle, err_cnt increments by 1.

FSM:
- SEARCH: locked=0. A vsync rise at LS goes to ALIGN with good=0.
- ALIGN: any error goes to SEARCH. Each later vsync rise with no error since the previous one does good++. When good reaches LOCK_FRAMES, go to LOCKED.
- LOCKED: locked=1. Any error goes to SEARCH, pulses lock_lost and increments err_cnt.
- err_cnt clears only on rst.

Output timing:
- pixel_valid and frame_start are combinational from the registered hx, vy and locked.
- A VGA sequence delayed one cycle, as delivered by the video controller, yields hx and vy equal to the controller's counters delayed one cycle.

Test Plan:
- Ideal 800x525 timing from reset → locked rises at the LS of the 3rd vsync rise; hx/vy equal the generator delayed 1 cycle; 307200 pixel_valid cycles per frame; frame_start once per frame.
- While locked, one line of 799 clocks → h_err at that LS, lock_lost, locked=0, err_cnt=1; relock after 2 further clean frames.
- While locked, hsync width 95 → h_err at HF with hx=94, lock drop, err_cnt=1.
- While locked, vsync suppressed for one frame → v_err at the LS where vy_next=490, lock drop.
- hsync held low in ALIGN → single h_err when hx reaches 1023; hx then stays 1023; FSM in SEARCH.
- rst pulsed mid-frame with hsync high → no false LS; all outputs 0; lock regained after 2 clean frames; err_cnt=0.
